// File: rtl/sparc_fetch_unit.sv
// rtl/sparc_fetch_unit.sv - SPARC instruction-fetch front end with PC/nPC pair and IF/ID register
//
// Purpose:
//   Holds the architectural PC/nPC pair, addresses the combinational
//   instruction ROM from PC, and captures the fetched word into the IF/ID
//   register. A taken branch only redirects nPC, so the word after the
//   branch (the delay slot) is always fetched.
//
// Ports:
//   clk_i            rising-edge clock
//   clr_i            synchronous active-high reset, overrides everything
//   le_pc_i          PC/nPC load enable (0 = stall, branch_taken ignored)
//   le_ifid_i        IF/ID load enable (0 = hold)
//   squash_i         load NOP_WORD bubble into IF/ID at this edge
//   branch_taken_i   resolved taken branch/call/jmpl
//   branch_target_i  branch target; bits [1:0] forced to 00
//   imem_addr_o      PC[ADDR_W-1:0], combinational ROM address
//   imem_data_i      ROM word at imem_addr_o, same cycle
//   instr_o          IF/ID instruction word
//   instr_pc_o       PC of the word in instr_o
//   instr_valid_o    1 = real fetched word, 0 = reset/squash bubble

module sparc_fetch_unit #(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              le_pc_i,
    input  logic              le_ifid_i,
    input  logic              squash_i,
    input  logic              branch_taken_i,
    input  logic [31:0]       branch_target_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_data_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       instr_pc_o,
    output logic              instr_valid_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    always_comb begin
        pc_d          = pc_q;
        npc_d         = npc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        // PC always advances to nPC; a taken branch only replaces the
        // next nPC, which is what makes the delay slot execute.
        if (le_pc_i) begin
            pc_d = npc_q;
            if (branch_taken_i) begin
                npc_d = {branch_target_i[31:2], 2'b00};
            end else begin
                npc_d = npc_q + 32'd4;
            end
        end

        // Squash wins over le_ifid so an annulled slot always becomes a bubble.
        if (squash_i) begin
            instr_d       = NOP_WORD;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b0;
        end else if (le_ifid_i) begin
            instr_d       = imem_data_i;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            pc_q          <= RESET_PC;
            npc_q         <= RESET_PC + 32'd4;
            instr_q       <= NOP_WORD;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            npc_q         <= npc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_addr_o   = pc_q[ADDR_W-1:0];
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;

endmodule

// File: tb/tb_sparc_fetch_unit.sv
// tb/tb_sparc_fetch_unit.sv - directed self-checking bench for sparc_fetch_unit

module tb_sparc_fetch_unit;

    localparam int ADDR_W = 9;

    logic              clk;
    logic              clr;
    logic              le_pc;
    logic              le_ifid;
    logic              squash;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic              instr_valid;

    int n_checks = 0;
    int n_fail   = 0;

    sparc_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .clr_i          (clr),
        .le_pc_i        (le_pc),
        .le_ifid_i      (le_ifid),
        .squash_i       (squash),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .imem_addr_o    (imem_addr),
        .imem_data_i    (imem_data),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_valid_o  (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        case (a)
            9'd0:    rom_word = 32'h8A00_0000;
            9'd4:    rom_word = 32'h86A0_E001;
            9'd8:    rom_word = 32'hC408_0001;
            9'd12:   rom_word = 32'hCA28_6001;
            default: rom_word = {16'hD00D, 7'd0, a};
        endcase
    endfunction

    assign imem_data = rom_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the IF/ID triple and the current fetch address.
    task automatic check_ifid(input string tag, input logic [31:0] exp_pc,
                              input logic exp_valid, input logic [31:0] exp_addr);
        logic [31:0] exp_instr;
        exp_instr = exp_valid ? rom_word(exp_pc[ADDR_W-1:0]) : 32'h0;
        check_eq({tag, ".instr"},     instr,                exp_instr);
        check_eq({tag, ".instr_pc"},  instr_pc,             exp_pc);
        check_eq({tag, ".valid"},     {31'd0, instr_valid}, {31'd0, exp_valid});
        check_eq({tag, ".imem_addr"}, {23'd0, imem_addr},   exp_addr);
    endtask

    initial begin
        clr = 1'b1; le_pc = 1'b1; le_ifid = 1'b1; squash = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;

        // Reset for two edges
        step();
        step();
        check_ifid("reset", 32'h0, 1'b0, 32'h0);

        // Sequential fetch; PC=8 when branch is raised below
        clr = 1'b0;
        step(); check_ifid("seq0", 32'h0, 1'b1, 32'h4);
        step(); check_ifid("seq4", 32'h4, 1'b1, 32'h8);

        // Taken branch while PC=8 -> 8, 12 (delay slot), 0x40, 0x44
        branch_taken = 1'b1; branch_target = 32'h0000_0040;
        step(); check_ifid("br8", 32'h8, 1'b1, 32'hC);
        branch_taken = 1'b0;
        step(); check_ifid("br_slot", 32'hC, 1'b1, 32'h40);
        step(); check_ifid("br_tgt", 32'h40, 1'b1, 32'h44);
        step(); check_ifid("br_tgt4", 32'h44, 1'b1, 32'h48);

        // Full stall for two edges
        le_pc = 1'b0; le_ifid = 1'b0;
        step(); check_ifid("stall1", 32'h44, 1'b1, 32'h48);
        step(); check_ifid("stall2", 32'h44, 1'b1, 32'h48);

        // PC stalled, IF/ID enabled: same PC word reloaded twice
        le_ifid = 1'b1;
        step(); check_ifid("reload1", 32'h48, 1'b1, 32'h48);
        step(); check_ifid("reload2", 32'h48, 1'b1, 32'h48);

        // Resume
        le_pc = 1'b1;
        step(); check_ifid("resume1", 32'h48, 1'b1, 32'h4C);
        step(); check_ifid("resume2", 32'h4C, 1'b1, 32'h50);

        // Squash with a taken branch: bubble, delay slot, target
        squash = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0080;
        step(); check_ifid("sq_bubble", 32'h50, 1'b0, 32'h54);
        squash = 1'b0; branch_taken = 1'b0;
        step(); check_ifid("sq_slot", 32'h54, 1'b1, 32'h80);
        step(); check_ifid("sq_tgt", 32'h80, 1'b1, 32'h84);

        // Branch to the top of the address space; low target bits ignored
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step(); check_ifid("wr_br", 32'h84, 1'b1, 32'h88);
        branch_taken = 1'b0;
        step(); check_ifid("wr_slot", 32'h88, 1'b1, 32'h1FC);
        step(); check_ifid("wr_top", 32'hFFFF_FFFC, 1'b1, 32'h0);
        step(); check_ifid("wr_zero", 32'h0, 1'b1, 32'h4);

        // Reset coincident with a taken branch discards the branch
        clr = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0100;
        step(); check_ifid("clr_br", 32'h0, 1'b0, 32'h0);
        clr = 1'b0; branch_taken = 1'b0;
        step(); check_ifid("post_clr0", 32'h0, 1'b1, 32'h4);
        step(); check_ifid("post_clr4", 32'h4, 1'b1, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
